// File: rtl/m_store_buf.sv
// M-stage store buffer: queues aligned stores and drains them to the
// data-memory port whenever a load is not using it.
module m_store_buf #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        StReq,
    input  logic [31:0] StPC,
    input  logic [31:0] StA,
    input  logic [31:0] StWD,
    input  logic [2:0]  StOp,
    input  logic        LdReq,
    input  logic [31:0] LdA,
    output logic        Stall,
    output logic        StErr,
    output logic        Empty,
    output logic        Full,
    output logic        DMWr,
    output logic [31:0] DMA,
    output logic [3:0]  DMBE,
    output logic [31:0] DMWD,
    output logic [31:0] DMPC
);

    localparam logic [2:0] DM_w = 3'b000;
    localparam logic [2:0] DM_h = 3'b001;
    localparam logic [2:0] DM_b = 3'b010;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CntMax = (AW + 1)'(DEPTH);

    logic [29:0] ent_wa   [DEPTH];
    logic [3:0]  ent_be   [DEPTH];
    logic [31:0] ent_wd   [DEPTH];
    logic [31:0] ent_pc   [DEPTH];
    logic [DEPTH-1:0] ent_v;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic        op_ok;
    logic        mis;
    logic [3:0]  st_be;
    logic [31:0] st_wd;
    logic        push;
    logic        pop;
    logic        hazard;
    logic        full_stall;

    // LdA byte offset does not matter for word-granular hazard checks
    logic unused_lda;
    assign unused_lda = ^LdA[1:0];

    assign Empty = (count == '0);
    assign Full  = (count == CntMax);

    // Byte enables, lane-replicated data and alignment check per op
    always_comb begin
        op_ok = 1'b0;
        mis   = 1'b0;
        st_be = 4'b0000;
        st_wd = 32'h0;
        unique case (StOp)
            DM_w: begin
                op_ok = 1'b1;
                mis   = (StA[1:0] != 2'b00);
                st_be = 4'b1111;
                st_wd = StWD;
            end
            DM_h: begin
                op_ok = 1'b1;
                mis   = StA[0];
                st_be = StA[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{StWD[15:0]}};
            end
            DM_b: begin
                op_ok = 1'b1;
                st_be = 4'b0001 << StA[1:0];
                st_wd = {4{StWD[7:0]}};
            end
            default: begin
                op_ok = 1'b0;
            end
        endcase
    end

    assign StErr = StReq & op_ok & mis;
    assign push  = StReq & op_ok & ~mis & ~Full;

    // Load hits any queued word or the word currently being written
    always_comb begin
        hazard = 1'b0;
        if (LdReq) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_v[i] && (ent_wa[i] == LdA[31:2])) begin
                    hazard = 1'b1;
                end
            end
            if (DMWr && (DMA[31:2] == LdA[31:2])) begin
                hazard = 1'b1;
            end
        end
    end

    assign full_stall = StReq & Full;
    assign Stall      = full_stall | hazard;
    assign pop        = ~Empty & (~LdReq | hazard);

    // Entry payload; only meaningful while the matching valid bit is set
    always_ff @(posedge Clk) begin
        if (push) begin
            ent_wa[wptr] <= StA[31:2];
            ent_be[wptr] <= st_be;
            ent_wd[wptr] <= st_wd;
            ent_pc[wptr] <= StPC;
        end
    end

    // Valid bits, pointers and occupancy
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ent_v <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                ent_v[rptr] <= 1'b0;
                rptr        <= rptr + 1'b1;
            end
            if (push) begin
                ent_v[wptr] <= 1'b1;
                wptr        <= wptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port; DMWr pulses only on a pop
    always_ff @(posedge Clk) begin
        if (Rst) begin
            DMWr <= 1'b0;
            DMA  <= 32'h0;
            DMBE <= 4'h0;
            DMWD <= 32'h0;
            DMPC <= 32'h0;
        end else if (pop) begin
            DMWr <= 1'b1;
            DMA  <= {ent_wa[rptr], 2'b00};
            DMBE <= ent_be[rptr];
            DMWD <= ent_wd[rptr];
            DMPC <= ent_pc[rptr];
        end else begin
            DMWr <= 1'b0;
        end
    end

endmodule
